txn_window_checker: RTL
=======================

TXN_WINDOW_CHECKER -- requirements
Module: txn_window_checker

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 2, number of independent channels; MIN_LAT, default 2, minimum start-to-done cycles (>=1); MAX_LAT, default 4, maximum start-to-done cycles (>=MIN_LAT); CNT_W, default 8, width of the event counters.
REQ-002 Ports SHALL be, clock and reset first:
  clk  in  1  single clock; all logic on its rising edge
  rst_n  in  1  reset, synchronous, active-low
  start  in  NUM_CH  per-channel transaction start
  done  in  NUM_CH  per-channel transaction completion
  valid  in  NUM_CH  per-channel handshake valid, sampled with start
  ready  in  NUM_CH  per-channel handshake ready, sampled with start
  clr  in  1  synchronous clear of pass_cnt/fail_cnt only
  busy  out  NUM_CH  channel has an outstanding transaction
  pass_pulse  out  NUM_CH  one-cycle pass indication
  fail_pulse  out  NUM_CH  one-cycle fail indication
  fail_code  out  3*NUM_CH  per-channel reason, channel i at bits [3i+2:3i]
  pass_cnt  out  CNT_W  total passes, all channels, saturating
  fail_cnt  out  CNT_W  total fails, all channels, saturating

Function
REQ-003 Each channel SHALL run an independent FSM with states IDLE and WAIT, plus a latency counter k that is clog2(MAX_LAT+2) bits wide.
REQ-004 A start in cycle T SHALL be latched as a transaction. k is 0 in cycle T, and done in cycle T+k is judged at latency k.
REQ-005 A start in IDLE with valid&&ready high SHALL move the channel to WAIT with k=1 in the next cycle.
REQ-006 A start in IDLE with valid&&ready not both high SHALL fail with code 1 (HANDSHAKE), and the channel SHALL stay IDLE.
REQ-007 In WAIT, done at MIN_LAT<=k<=MAX_LAT SHALL pass and return the channel to IDLE.
REQ-008 In WAIT, done at k<MIN_LAT SHALL fail with code 2 (EARLY) and return the channel to IDLE.
REQ-009 In WAIT with no done at k=MAX_LAT, the channel SHALL fail with code 3 (TIMEOUT) in the next cycle, judged at k=MAX_LAT+1, and return to IDLE.
REQ-010 done in IDLE SHALL fail with code 4 (ORPHAN).
REQ-011 start in WAIT without done SHALL fail the old transaction with code 5 (OVERLAP); the new start SHALL then be evaluated per REQ-005/006, with a handshake failure taking precedence over OVERLAP in the reported code.
REQ-012 start and done together in WAIT SHALL resolve the old transaction per REQ-007/008 first and then evaluate the new start per REQ-005/006. If both produce a result in the same cycle, a fail SHALL take precedence for the pulse and the counters SHALL count one event.
REQ-013 start and done together in IDLE SHALL report ORPHAN, and the start SHALL still be evaluated, with a handshake fail overriding the code.
REQ-014 pass_pulse, fail_pulse and fail_code SHALL be registered and asserted in the cycle after the deciding edge, for exactly one cycle.
REQ-015 pass_pulse and fail_pulse SHALL never be high together on a channel.
REQ-016 fail_code SHALL be 0 whenever fail_pulse is low.
REQ-017 busy SHALL be high exactly while the channel is in WAIT.
REQ-018 pass_cnt SHALL add popcount(pass_pulse) each cycle and fail_cnt SHALL add popcount(fail_pulse) each cycle. Each counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 clr SHALL zero both counters next cycle. If clr coincides with pulses, clr SHALL win and those pulses SHALL not be counted.
REQ-020 Channels SHALL share no state except the two counters.

Reset
REQ-021 With rst_n low at a clock edge, every FSM SHALL go to IDLE and k SHALL be set to 0.
REQ-022 With rst_n low at a clock edge, busy, pass_pulse, fail_pulse, fail_code, pass_cnt and fail_cnt SHALL all be 0 from the next cycle.
REQ-023 Reset asserted mid-transaction SHALL discard that transaction without any pass or fail report.
REQ-024 Inputs SHALL be ignored in any cycle where rst_n is low.

Verification
REQ-025 The bench SHALL cover these scenarios, with defaults unless stated:
  - ch0 start with valid=ready=1, done 2 cycles later -> ch0 pass_pulse one cycle after done; pass_cnt=1, fail_cnt=0.
  - ch0 start with valid=1, ready=0 -> fail_pulse next cycle with fail_code=1; busy stays 0; fail_cnt=1.
  - ch1 start accepted, no done -> busy high for 4 cycles; fail_code=3 for ch1, asserted 6 cycles after start.
  - ch0 done with no transaction outstanding -> fail_code=4; ch0 start then done 1 cycle later -> fail_code=2.
  - ch0 pass and ch1 fail in the same cycle -> pass_cnt and fail_cnt each +1. With CNT_W=2 and 5 fails, fail_cnt holds 3.
  - Reset asserted while ch0 is in WAIT, then released -> busy=0 and no pulses; clr alone zeroes the counters next cycle.

Source files
------------

// File: rtl/txn_window_checker.sv
// Per-channel transaction latency checker: judges each start/done pair against a
// [MIN_LAT, MAX_LAT] window and keeps shared saturating pass/fail event counters.
module txn_window_checker #(
    parameter int NUM_CH  = 2,
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 4,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     start,
    input  logic [NUM_CH-1:0]     done,
    input  logic [NUM_CH-1:0]     valid,
    input  logic [NUM_CH-1:0]     ready,
    input  logic                  clr,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     pass_pulse,
    output logic [NUM_CH-1:0]     fail_pulse,
    output logic [3*NUM_CH-1:0]   fail_code,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt
);

    localparam int K_W   = $clog2(MAX_LAT + 2);
    localparam int SUM_W = CNT_W + $clog2(NUM_CH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [2:0] CODE_HANDSHAKE = 3'd1;
    localparam logic [2:0] CODE_EARLY     = 3'd2;
    localparam logic [2:0] CODE_TIMEOUT   = 3'd3;
    localparam logic [2:0] CODE_ORPHAN    = 3'd4;
    localparam logic [2:0] CODE_OVERLAP   = 3'd5;

    localparam logic [K_W-1:0] K_ONE = K_W'(1);
    localparam logic [K_W-1:0] K_MIN = K_W'(MIN_LAT);
    localparam logic [K_W-1:0] K_MAX = K_W'(MAX_LAT);
    localparam logic [K_W-1:0] K_TO  = K_W'(MAX_LAT + 1);

    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [0:0]     state_reg, state_next;
            logic [K_W-1:0] k_reg, k_next;
            logic           pass_reg, pass_next;
            logic           fail_reg, fail_next;
            logic [2:0]     code_reg, code_next;
            logic           hs_ok;

            assign hs_ok = valid[gi] && ready[gi];

            always_comb begin
                state_next = state_reg;
                k_next     = k_reg;
                pass_next  = 1'b0;
                fail_next  = 1'b0;
                code_next  = 3'd0;

                if (state_reg == ST_IDLE) begin
                    // k parked at MAX_LAT+1 means a timeout is judged this cycle
                    if (k_reg == K_TO) begin
                        fail_next = 1'b1;
                        code_next = CODE_TIMEOUT;
                        k_next    = '0;
                    end else if (done[gi]) begin
                        fail_next = 1'b1;
                        code_next = CODE_ORPHAN;
                    end
                end else begin
                    if (done[gi]) begin
                        if (k_reg < K_MIN) begin
                            fail_next = 1'b1;
                            code_next = CODE_EARLY;
                        end else begin
                            pass_next = 1'b1;
                        end
                        state_next = ST_IDLE;
                        k_next     = '0;
                    end else if (start[gi]) begin
                        fail_next = 1'b1;
                        code_next = CODE_OVERLAP;
                    end else if (k_reg == K_MAX) begin
                        state_next = ST_IDLE;
                        k_next     = K_TO;
                    end else begin
                        k_next = k_reg + K_ONE;
                    end
                end

                // The new start is evaluated after the old transaction is resolved
                if (start[gi]) begin
                    if (hs_ok) begin
                        state_next = ST_WAIT;
                        k_next     = K_ONE;
                    end else begin
                        fail_next  = 1'b1;
                        code_next  = CODE_HANDSHAKE;
                        state_next = ST_IDLE;
                        k_next     = '0;
                    end
                end

                if (fail_next) begin
                    pass_next = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg <= ST_IDLE;
                    k_reg     <= '0;
                    pass_reg  <= 1'b0;
                    fail_reg  <= 1'b0;
                    code_reg  <= 3'd0;
                end else begin
                    state_reg <= state_next;
                    k_reg     <= k_next;
                    pass_reg  <= pass_next;
                    fail_reg  <= fail_next;
                    code_reg  <= code_next;
                end
            end

            assign busy[gi]            = (state_reg == ST_WAIT);
            assign pass_pulse[gi]      = pass_reg;
            assign fail_pulse[gi]      = fail_reg;
            assign fail_code[3*gi +: 3] = code_reg;
        end
    endgenerate

    logic [CNT_W-1:0] pass_cnt_reg, pass_cnt_next;
    logic [CNT_W-1:0] fail_cnt_reg, fail_cnt_next;
    logic [SUM_W-1:0] pass_pop, fail_pop, pass_sum, fail_sum;

    always_comb begin
        pass_pop = '0;
        fail_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pass_pop = pass_pop + SUM_W'(pass_pulse[i]);
            fail_pop = fail_pop + SUM_W'(fail_pulse[i]);
        end
        pass_sum      = SUM_W'(pass_cnt_reg) + pass_pop;
        fail_sum      = SUM_W'(fail_cnt_reg) + fail_pop;
        pass_cnt_next = (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
        fail_cnt_next = (fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pass_cnt_reg <= '0;
            fail_cnt_reg <= '0;
        end else begin
            pass_cnt_reg <= pass_cnt_next;
            fail_cnt_reg <= fail_cnt_next;
        end
    end

    assign pass_cnt = pass_cnt_reg;
    assign fail_cnt = fail_cnt_reg;

endmodule
